// File: rtl/sram_lsu_master_pkg.sv
// Shared types for the SRAM load/store master: access size codes, FSM states and
// byte-lane helpers used by the top level.
package sram_lsu_master_pkg;

    typedef enum logic [1:0] {
        SzByte = 2'b00,
        SzHalf = 2'b01,
        SzWord = 2'b10,
        SzBad  = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StResp   = 2'b10
    } lsu_state_e;

    localparam int unsigned WaitBits = 4;

    function automatic logic [3:0] byte_enable(lsu_size_e size, logic [1:0] off);
        logic [3:0] be;
        unique case (size)
            SzByte:  be = 4'b0001 << off;
            SzHalf:  be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across every lane so the byte enables alone pick the target.
    function automatic logic [31:0] replicate(lsu_size_e size, logic [31:0] data);
        logic [31:0] rep;
        unique case (size)
            SzByte:  rep = {4{data[7:0]}};
            SzHalf:  rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/sram_lsu_master_load_align.sv
// Combinational load alignment: shifts the addressed lanes down, truncates to the
// access size and zero/sign-extends to 32 bits.
module sram_lsu_master_load_align
    import sram_lsu_master_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  lsu_size_e   size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = shifted;
        unique case (size_i)
            SzByte:  data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
            SzHalf:  data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/sram_lsu_master.sv
// Load/store initiator for a word-addressed, byte-enabled SRAM: checks each request,
// runs a fixed-length access and returns a registered, aligned response.
module sram_lsu_master
    import sram_lsu_master_pkg::*;
#(
    parameter int unsigned WORD_ADDR_BITS = 14,
    parameter int unsigned WAIT_CYCLES    = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic [1:0]                req_size_i,
    input  logic                      req_unsigned_i,
    input  logic [31:0]               req_addr_i,
    input  logic [31:0]               req_wdata_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [31:0]               resp_rdata_o,
    output logic                      resp_err_o,
    output logic [WORD_ADDR_BITS-1:0] sram_addr_o,
    output logic                      sram_read_o,
    output logic [3:0]                sram_write_o,
    output logic [31:0]               sram_di_o,
    input  logic [31:0]               sram_do_i
);

    localparam int unsigned AW = WORD_ADDR_BITS + 2;
    localparam logic [WaitBits-1:0] LastWait = WaitBits'(WAIT_CYCLES);

    lsu_state_e          state_q, state_d;
    logic                we_q, we_d;
    lsu_size_e           size_q, size_d;
    logic                uns_q, uns_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [WaitBits-1:0] wait_q, wait_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                req_err;
    logic [31:0]         load_data;
    lsu_size_e           req_size;

    assign req_size = lsu_size_e'(req_size_i);

    always_comb begin
        req_err = 1'b0;
        unique case (req_size)
            SzByte:  req_err = 1'b0;
            SzHalf:  req_err = req_addr_i[0];
            SzWord:  req_err = |req_addr_i[1:0];
            default: req_err = 1'b1;
        endcase
        if ((req_addr_i >> AW) != 32'd0) begin
            req_err = 1'b1;
        end
    end

    sram_lsu_master_load_align u_load_align (
        .rdata_i    (sram_do_i),
        .offset_i   (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (load_data)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    size_d  = req_size;
                    uns_d   = req_unsigned_i;
                    addr_d  = req_addr_i[AW-1:0];
                    wdata_d = req_wdata_i;
                    wait_d  = '0;
                    rdata_d = '0;
                    if (req_err) begin
                        state_d = StResp;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StAccess;
                        err_d   = 1'b0;
                    end
                end
            end
            StAccess: begin
                if (wait_q == LastWait) begin
                    state_d = StResp;
                    rdata_d = we_q ? 32'd0 : load_data;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StResp: begin
                if (resp_ready_i) begin
                    state_d = StIdle;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            size_q  <= SzByte;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Write strobes only in the first access cycle so a multi-cycle access commits once.
    always_comb begin
        sram_addr_o  = '0;
        sram_read_o  = 1'b0;
        sram_write_o = 4'b0000;
        sram_di_o    = '0;
        if (state_q == StAccess) begin
            sram_addr_o = addr_q[AW-1:2];
            sram_read_o = ~we_q;
            if (we_q) begin
                sram_di_o = replicate(size_q, wdata_q);
                if (wait_q == '0) begin
                    sram_write_o = byte_enable(size_q, addr_q[1:0]);
                end
            end
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = (state_q == StResp);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_sram_lsu_master.sv
// Directed bench for sram_lsu_master with a behavioural byte-enabled SRAM model.
module tb_sram_lsu_master;

    localparam int unsigned W   = 3;
    localparam int unsigned WAB = 14;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_we = 1'b0;
    logic [1:0]     req_size = 2'b00;
    logic           req_unsigned = 1'b0;
    logic [31:0]    req_addr = 32'd0;
    logic [31:0]    req_wdata = 32'd0;
    logic           resp_valid;
    logic           resp_ready = 1'b1;
    logic [31:0]    resp_rdata;
    logic           resp_err;
    logic [WAB-1:0] sram_addr;
    logic           sram_read;
    logic [3:0]     sram_write;
    logic [31:0]    sram_di;
    logic [31:0]    sram_do;

    logic [31:0]    mem [0:(1<<WAB)-1];
    int             n_chk = 0;
    int             n_pass = 0;
    int             lat_bp;

    always #5 clk = ~clk;

    sram_lsu_master #(
        .WORD_ADDR_BITS (WAB),
        .WAIT_CYCLES    (W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_rdata_o   (resp_rdata),
        .resp_err_o     (resp_err),
        .sram_addr_o    (sram_addr),
        .sram_read_o    (sram_read),
        .sram_write_o   (sram_write),
        .sram_di_o      (sram_di),
        .sram_do_i      (sram_do)
    );

    // SRAM model: byte writes on the edge, DO junk when not reading.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (sram_write[b]) mem[sram_addr][8*b +: 8] <= sram_di[8*b +: 8];
        end
    end
    assign sram_do = sram_read ? mem[sram_addr] : 32'h5A5A_5A5A;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic run(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata,
                       input logic [3:0] exp_be, input logic [31:0] exp_di);
        int         lat;
        int         wr_n;
        int         rd_n;
        logic [3:0] be;
        logic [31:0] di;
        logic       sa_ok;
        lat = 0; wr_n = 0; rd_n = 0; be = 4'd0; di = 32'd0; sa_ok = 1'b1;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        tick();
        // Scramble request inputs: the DUT must use its latched copy.
        req_valid = 1'b0; req_we = ~we; req_size = 2'b11; req_unsigned = ~uns;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            if (resp_valid) begin
                lat = c;
                break;
            end
            if (sram_write != 4'd0) begin
                wr_n++;
                be = sram_write;
                di = sram_di;
            end
            if (sram_read) rd_n++;
            if ((sram_read || sram_write != 4'd0) && sram_addr != addr[WAB+1:2]) sa_ok = 1'b0;
            tick();
        end
        chk({tag, ".latency"}, 32'(lat), exp_err ? 32'd1 : 32'(W + 2));
        chk({tag, ".err"}, 32'(resp_err), 32'(exp_err));
        chk({tag, ".rdata"}, resp_rdata, exp_rdata);
        chk({tag, ".write_cycles"}, 32'(wr_n), (!exp_err && we) ? 32'd1 : 32'd0);
        chk({tag, ".read_cycles"}, 32'(rd_n), (!exp_err && !we) ? 32'(W + 1) : 32'd0);
        chk({tag, ".byte_en"}, 32'(be), 32'(exp_be));
        chk({tag, ".di"}, di, exp_di);
        chk({tag, ".sram_addr"}, 32'(sa_ok), 32'd1);
        tick();
        chk({tag, ".valid_cleared"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << WAB); i++) mem[i] = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_err", 32'(resp_err), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.sram_read", 32'(sram_read), 32'd0);
        chk("rst.sram_write", 32'(sram_write), 32'd0);
        chk("rst.sram_addr", 32'(sram_addr), 32'd0);
        chk("rst.sram_di", sram_di, 32'd0);

        // Word store/load round trip.
        run("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0, 4'b1111, 32'hDEAD_BEEF);
        run("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF, 4'd0, 32'd0);

        // Byte lane 3: mem[4] becomes 0xA5ADBEEF.
        run("st_b13", 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00A5, 1'b0, 32'd0, 4'b1000, 32'hA5A5_A5A5);
        run("ld_b13s", 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 1'b0, 32'hFFFF_FFA5, 4'd0, 32'd0);
        run("ld_b13u", 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 1'b0, 32'h0000_00A5, 4'd0, 32'd0);
        run("ld_b12u", 1'b0, 2'b00, 1'b1, 32'h12, 32'd0, 1'b0, 32'h0000_00AD, 4'd0, 32'd0);

        // Halves of 0x80017FFF, then upper half overwritten: mem[4] = 0x12347FFF.
        run("st_w10b", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8001_7FFF, 1'b0, 32'd0, 4'b1111, 32'h8001_7FFF);
        run("ld_h12s", 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 1'b0, 32'hFFFF_8001, 4'd0, 32'd0);
        run("ld_h10s", 1'b0, 2'b01, 1'b0, 32'h10, 32'd0, 1'b0, 32'h0000_7FFF, 4'd0, 32'd0);
        run("ld_h12u", 1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 1'b0, 32'h0000_8001, 4'd0, 32'd0);
        run("st_h12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234, 1'b0, 32'd0, 4'b1100, 32'h1234_1234);
        run("ld_w10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, 32'h1234_7FFF, 4'd0, 32'd0);

        // Error requests never touch the SRAM.
        run("err_w11", 1'b0, 2'b10, 1'b0, 32'h11, 32'd0, 1'b1, 32'd0, 4'd0, 32'd0);
        run("err_h01", 1'b1, 2'b01, 1'b0, 32'h01, 32'hFFFF, 1'b1, 32'd0, 4'd0, 32'd0);
        run("err_sz3", 1'b0, 2'b11, 1'b0, 32'h00, 32'd0, 1'b1, 32'd0, 4'd0, 32'd0);
        run("err_rng", 1'b1, 2'b10, 1'b0, 32'h0001_0000, 32'hCAFE_F00D, 1'b1, 32'd0, 4'd0, 32'd0);
        run("ld_w10d", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, 32'h1234_7FFF, 4'd0, 32'd0);
        run("ld_w00", 1'b0, 2'b10, 1'b0, 32'h00, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0);

        // Backpressure: response held, competing store refused.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
        tick();
        req_valid = 1'b0;
        lat_bp = 0;
        for (int c = 1; c <= 40; c++) begin
            if (resp_valid) begin
                lat_bp = c;
                break;
            end
            tick();
        end
        chk("bp.latency", 32'(lat_bp), 32'(W + 2));
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20;
        req_wdata = 32'h1111_1111;
        for (int i = 0; i < 5; i++) begin
            chk("bp.resp_valid", 32'(resp_valid), 32'd1);
            chk("bp.rdata", resp_rdata, 32'h1234_7FFF);
            chk("bp.err", 32'(resp_err), 32'd0);
            chk("bp.req_ready", 32'(req_ready), 32'd0);
            chk("bp.sram_write", 32'(sram_write), 32'd0);
            tick();
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        chk("bp.valid_cleared", 32'(resp_valid), 32'd0);
        chk("bp.req_ready_back", 32'(req_ready), 32'd1);
        chk("bp.no_store", mem[8], 32'd0);

        // Reset during the access of a load.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
        tick();
        req_valid = 1'b0;
        chk("rstmid.reading", 32'(sram_read), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid.resp_valid", 32'(resp_valid), 32'd0);
        chk("rstmid.req_ready", 32'(req_ready), 32'd1);
        chk("rstmid.sram_read", 32'(sram_read), 32'd0);
        chk("rstmid.sram_write", 32'(sram_write), 32'd0);
        chk("rstmid.sram_addr", 32'(sram_addr), 32'd0);
        chk("rstmid.sram_di", sram_di, 32'd0);
        tick();
        chk("rstmid.still_idle", 32'(resp_valid), 32'd0);
        run("rstmid.ld", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, 32'h1234_7FFF, 4'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
